// File: rtl/regfile_pkg.sv
// Shared widths, address/word types and the write-back staging entry for the register file.
// Types only; no logic, no latency, no flow control.
// Other files pull these in with import regfile_pkg::*.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] regaddr_t;

    localparam regaddr_t ZERO_REG = '0;

    typedef struct packed {
        logic     vld;
        regaddr_t addr;
        word_t    dat;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_decoder1to32.sv
// One-hot write-enable decoder: address plus enable in, one enable line per register out.
// Latency: purely combinational.
// Backpressure: none; the output is all zeros whenever en is low.
module decoder1to32
    import regfile_pkg::*;
(
    input  logic [ADDR_W-1:0]   addr,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// 32x32 register file: two async read ports, one write port via a one-entry write-back stage; r0 reads 0.
// Latency: a write reaches the array one edge after capture; with REGFILE_BYPASS_EN it is readable right after capture.
// Backpressure: none; capture and commit share an edge, so back-to-back writes never stall.
module regfile_wb
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              wb_pending
);

    wb_entry_t             pend;
    logic                  cap;
    logic [NUM_REGS-1:0]   we;
    word_t                 mem [NUM_REGS];

    // Writes to r0 are dropped here so they never occupy the staging slot.
    assign cap = RegWrite && (WriteRegister != ZERO_REG);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend.vld <= cap;
            if (cap) begin
                pend.addr <= WriteRegister;
                pend.dat  <= WriteData;
            end
        end
    end

    decoder1to32 u_dec (
        .addr   (pend.addr),
        .en     (pend.vld),
        .onehot (we)
    );

    // Word 0 is a zero cell: its enable only ever reloads zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we[i]) begin
                    mem[i] <= (i == 0) ? '0 : pend.dat;
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic byp1;
    logic byp2;

    assign byp1 = pend.vld && (pend.addr == ReadRegister1);
    assign byp2 = pend.vld && (pend.addr == ReadRegister2);

    assign ReadData1 = (ReadRegister1 == ZERO_REG) ? '0 :
                       byp1 ? pend.dat : mem[ReadRegister1];
    assign ReadData2 = (ReadRegister2 == ZERO_REG) ? '0 :
                       byp2 ? pend.dat : mem[ReadRegister2];
`else
    // Without bypass the hazard unit must cover the one-cycle window before commit.
    assign ReadData1 = (ReadRegister1 == ZERO_REG) ? '0 : mem[ReadRegister1];
    assign ReadData2 = (ReadRegister2 == ZERO_REG) ? '0 : mem[ReadRegister2];
`endif

    assign wb_pending = pend.vld;

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed table, hand-written corner sequences and a random run vs a queue model.
module tb_regfile_wb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  ReadRegister1 = '0;
    logic [4:0]  ReadRegister2 = '0;
    logic [4:0]  WriteRegister = '0;
    logic [31:0] WriteData = '0;
    logic        RegWrite = 1'b0;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic        wb_pending;

    int total = 0;
    int bad   = 0;

    regfile_wb dut (
        .clk           (clk),
        .reset         (reset),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .wb_pending    (wb_pending)
    );

    always #5 clk = ~clk;

    // Reference: architectural array plus a queue of writes awaiting their commit edge.
    logic [31:0] m_arr [32];
    typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
    wr_t m_q[$];

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_arr[i] = '0;
        m_q.delete();
    endfunction

    function automatic void model_edge(logic w, logic [4:0] a, logic [31:0] d);
        wr_t e;
        if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_arr[e.a] = e.d;
        end
        if (w && a != 0) begin
            e.a = a;
            e.d = d;
            m_q.push_back(e);
        end
    endfunction

    function automatic logic [31:0] model_read(logic [4:0] a);
        if (a == 0) return '0;
        if (BYP && m_q.size() > 0 && m_q[0].a == a) return m_q[0].d;
        return m_arr[a];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive one write request, advance one edge, and leave time at edge+1 for sampling.
    task automatic cyc(logic w, logic [4:0] a, logic [31:0] d);
        RegWrite      = w;
        WriteRegister = a;
        WriteData     = d;
        @(posedge clk);
        model_edge(w, a, d);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        ep;
    } vec_t;

    vec_t tbl [8];
    logic        rw;
    logic [4:0]  ra;
    logic [31:0] rd;

    initial begin
        // r5 write, r0 write, then back-to-back r3,r3,r7 from a freshly reset file.
        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 1'b1};
        tbl[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        tbl[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 1'b0};
        tbl[3] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 32'h0, 32'h0, 1'b0};
        tbl[4] = '{1'b1, 5'd3, 32'h1,        5'd3, 5'd7, BYP ? 32'h1 : 32'h0, 32'h0, 1'b1};
        tbl[5] = '{1'b1, 5'd3, 32'h2,        5'd3, 5'd7, BYP ? 32'h2 : 32'h1, 32'h0, 1'b1};
        tbl[6] = '{1'b1, 5'd7, 32'h3,        5'd3, 5'd7, 32'h2, BYP ? 32'h3 : 32'h0, 1'b1};
        tbl[7] = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd7, 32'h2, 32'h3, 1'b0};

        model_reset();

        // Asynchronous reset: outputs must clear with no clock edge involved.
        #1 reset = 1'b1;
        #2;
        chk("rst_pending", {31'b0, wb_pending}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            #1;
            chk("rst_rd1", ReadData1, 32'h0);
            chk("rst_rd2", ReadData2, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 8; v++) begin
            ReadRegister1 = tbl[v].r1;
            ReadRegister2 = tbl[v].r2;
            cyc(tbl[v].we, tbl[v].wa, tbl[v].wd);
            chk($sformatf("vec%0d_rd1", v), ReadData1, tbl[v].e1);
            chk($sformatf("vec%0d_rd2", v), ReadData2, tbl[v].e2);
            chk($sformatf("vec%0d_pend", v), {31'b0, wb_pending}, {31'b0, tbl[v].ep});
        end

        // Pending write to r9 is dropped by a reset before its commit edge.
        ReadRegister1 = 5'd9;
        ReadRegister2 = 5'd3;
        cyc(1'b1, 5'd9, 32'h12345678);
        chk("r9_pend", {31'b0, wb_pending}, 32'h1);
        chk("r9_capture", ReadData1, BYP ? 32'h12345678 : 32'h0);
        RegWrite = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("r9_rst_pend", {31'b0, wb_pending}, 32'h0);
        chk("r9_rst_rd", ReadData1, 32'h0);
        chk("r3_rst_rd", ReadData2, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b0, 5'd0, 32'h0);
        chk("r9_after", ReadData1, 32'h0);
        chk("r9_after_pend", {31'b0, wb_pending}, 32'h0);

        // Fill r1..r31 and sweep both ports in opposite directions.
        for (int i = 1; i < 32; i++) cyc(1'b1, 5'(i), 32'(i) * 32'h01010101);
        cyc(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            cyc(1'b0, 5'd0, 32'h0);
            chk("sweep_rd1", ReadData1, 32'(i) * 32'h01010101);
            chk("sweep_rd2", ReadData2, 32'(31 - i) * 32'h01010101);
        end

        // Random traffic with a bias towards a few addresses to provoke read-after-write hazards.
        for (int n = 0; n < 300; n++) begin
            rw = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            rd = $urandom;
            ReadRegister1 = ($urandom_range(0, 1) == 1) ? ra : 5'($urandom_range(0, 31));
            ReadRegister2 = 5'($urandom_range(0, 3));
            cyc(rw, ra, rd);
            chk("rnd_rd1", ReadData1, model_read(ReadRegister1));
            chk("rnd_rd2", ReadData2, model_read(ReadRegister2));
            chk("rnd_pend", {31'b0, wb_pending}, {31'b0, m_q.size() > 0});
        end

        // Mid-cycle reset on a populated file clears every word immediately.
        ReadRegister1 = 5'd1;
        cyc(1'b1, 5'd2, 32'hA5A5A5A5);
        RegWrite = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_pend", {31'b0, wb_pending}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(i);
            #1;
            chk("mid_rst_rd1", ReadData1, 32'h0);
            chk("mid_rst_rd2", ReadData2, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        ReadRegister1 = 5'd2;
        cyc(1'b0, 5'd0, 32'h0);
        chk("post_rst_r2", ReadData1, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
